// File: rtl/partial_product_generator.sv
// rtl/partial_product_generator.sv - serial multiply partial-product producer
//
// Streams DATA_WIDTH unshifted partial products, LSB-first, for one captured
// multiplicand/multiplier pair. A one-cycle acc_clear strobe precedes each
// stream so the downstream accumulator restarts without a global reset.
//
// Ports:
//   clk                    in   rising-edge clock
//   reset                  in   asynchronous active-high reset
//   start                  in   request a multiply (sampled only in IDLE)
//   multiplicand           in   operand A, captured on accepted start
//   multiplier             in   operand B, captured on accepted start
//   pp_ready               in   downstream accept for the current item
//   acc_clear              out  one-cycle strobe before the first item
//   partial_product        out  current partial product (0 when not valid)
//   partial_product_valid  out  partial_product is valid
//   pp_overflow            out  sticky: negated MSB item not representable
//   busy                   out  high in every state except IDLE
//   done                   out  one-cycle pulse after the last item
//
// Configuration macro: PPG_SIGNED_EN
//   defined   - two's-complement operands; MSB item is -A when B[MSB] = 1,
//               pp_overflow flags A = 100..0
//   undefined - unsigned operands; MSB item is A, pp_overflow tied to 0

module partial_product_generator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    input  logic                  pp_ready,
    output logic                  acc_clear,
    output logic [DATA_WIDTH-1:0] partial_product,
    output logic                  partial_product_valid,
    output logic                  pp_overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = $clog2(DATA_WIDTH) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  acc_clear_q, acc_clear_d;
    logic [DATA_WIDTH-1:0] pp_q, pp_d;
    logic                  pp_valid_q, pp_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    // Partial product for bit index k of the captured multiplier. Only the
    // MSB item differs between the unsigned and two's-complement builds.
    function automatic logic [DATA_WIDTH-1:0] pp_at(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [KW-1:0]         k
    );
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        if (b[k[KW-2:0]]) begin
`ifdef PPG_SIGNED_EN
            if (k == K_LAST) begin
                r = '0 - a;
            end else begin
                r = a;
            end
`else
            r = a;
`endif
        end
        return r;
    endfunction

    // Overflow condition of the MSB item: negating the most negative value
    // wraps back onto itself.
    function automatic logic msb_overflow(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return b[DATA_WIDTH-1] && (a == {1'b1, {(DATA_WIDTH-1){1'b0}}});
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        acc_clear_d = 1'b0;
        pp_d        = '0;
        pp_valid_d  = 1'b0;
        done_d      = 1'b0;
        ovf_d       = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d         = multiplicand;
                    b_d         = multiplier;
                    k_d         = '0;
                    ovf_d       = 1'b0;
                    acc_clear_d = 1'b1;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Pre-load item 0 so it is on the output the cycle EMIT begins.
                pp_valid_d = 1'b1;
                pp_d       = pp_at(a_q, b_q, '0);
`ifdef PPG_SIGNED_EN
                if (K_LAST == '0 && msb_overflow(a_q, b_q)) begin
                    ovf_d = 1'b1;
                end
`endif
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (pp_ready) begin
                    if (k_q == K_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // Outputs are registered, so the next item is
                        // computed from the incremented index.
                        k_d        = k_q + 1'b1;
                        pp_valid_d = 1'b1;
                        pp_d       = pp_at(a_q, b_q, k_q + 1'b1);
`ifdef PPG_SIGNED_EN
                        if ((k_q + 1'b1) == K_LAST && msb_overflow(a_q, b_q)) begin
                            ovf_d = 1'b1;
                        end
`endif
                    end
                end else begin
                    pp_valid_d = 1'b1;
                    pp_d       = pp_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            acc_clear_q <= 1'b0;
            pp_q        <= '0;
            pp_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            acc_clear_q <= acc_clear_d;
            pp_q        <= pp_d;
            pp_valid_q  <= pp_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign acc_clear             = acc_clear_q;
    assign partial_product       = pp_q;
    assign partial_product_valid = pp_valid_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
`ifdef PPG_SIGNED_EN
    assign pp_overflow           = ovf_q;
`else
    assign pp_overflow           = 1'b0;
`endif

endmodule

// File: tb/tb_partial_product_generator.sv
// tb/tb_partial_product_generator.sv - self-checking bench for partial_product_generator

module tb_partial_product_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] multiplicand = '0;
    logic [15:0] multiplier = '0;
    logic        pp_ready = 1'b1;
    logic        acc_clear;
    logic [15:0] partial_product;
    logic        partial_product_valid;
    logic        pp_overflow;
    logic        busy;
    logic        done;

    partial_product_generator #(.DATA_WIDTH(16)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .multiplicand          (multiplicand),
        .multiplier            (multiplier),
        .pp_ready              (pp_ready),
        .acc_clear             (acc_clear),
        .partial_product       (partial_product),
        .partial_product_valid (partial_product_valid),
        .pp_overflow           (pp_overflow),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // model state for the multiply in flight
    logic [15:0] exp_pp [16];
    logic [15:0] got [16];
    logic        model_ovf = 1'b0;
    logic        active = 1'b0;
    int          n = 0;
    int          clear_cnt = 0;
    int          done_cnt = 0;
    int          clear_cyc = -1;
    int          done_cyc = -1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_pp(input logic [15:0] a, input logic [15:0] b, input int k);
        if (!b[k]) return 16'h0000;
`ifdef PPG_SIGNED_EN
        if (k == 15) return 16'h0000 - a;
`endif
        return a;
    endfunction

    function automatic logic model_overflow(input logic [15:0] a, input logic [15:0] b);
`ifdef PPG_SIGNED_EN
        return b[15] && (a == 16'h8000);
`else
        return (a != a) || (b != b);
`endif
    endfunction

    // compare process: every cycle the outputs mean something
    always @(negedge clk) begin
        if (reset) begin
            check("outputs_in_reset",
                  longint'({acc_clear, partial_product, partial_product_valid, pp_overflow, busy, done}), 0);
        end else if (active) begin
            if (!partial_product_valid) check("pp_zero_when_invalid", longint'(partial_product), 0);
            if (acc_clear) begin
                clear_cnt++;
                clear_cyc = cyc;
                check("ovf_cleared_on_start", longint'(pp_overflow), 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("ovf_at_done", longint'(pp_overflow), longint'(model_ovf));
                check("busy_at_done", longint'(busy), 1);
            end
            if (partial_product_valid) begin
                if (n >= 16) begin
                    check("extra_item", n, 15);
                end else begin
                    check("stream_item", longint'(partial_product), longint'(exp_pp[n]));
                    check("ovf_during_stream", longint'(pp_overflow),
                          (n == 15) ? longint'(model_ovf) : 0);
                    if (pp_ready) begin
                        got[n] = partial_product;
                        n++;
                    end
                end
            end
        end
    end

    // One multiply. stall_k/stall_len: drop pp_ready while item stall_k is
    // presented. ignore_at: pulse start (with other operands) at that cycle.
    // rst_k: assert reset while item rst_k is presented.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int stall_k, input int stall_len,
                           input int ignore_at, input int rst_k);
        int t0;
        int stalls;
        bit aborted;
        longint sum;
        longint prod;
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_before_start", longint'(busy), 0);
        for (int k = 0; k < 16; k++) begin
            exp_pp[k] = model_pp(a, b, k);
            got[k] = 16'hDEAD;
        end
        model_ovf = model_overflow(a, b);
        n = 0;
        clear_cnt = 0;
        done_cnt = 0;
        clear_cyc = -1;
        done_cyc = -1;
        active = 1'b1;
        t0 = cyc;
        multiplicand = a;
        multiplier = b;
        start = 1'b1;
        pp_ready = 1'b1;
        stalls = stall_len;
        aborted = 1'b0;
        for (int i = 0; i < 100 && done_cnt == 0 && !aborted; i++) begin
            @(posedge clk);
            #1;
            start = (cyc - t0 == ignore_at);
            multiplicand = 16'($urandom);
            multiplier = 16'($urandom);
            pp_ready = 1'b1;
            if (partial_product_valid && n == stall_k && stalls > 0) begin
                pp_ready = 1'b0;
                stalls--;
            end
            if (partial_product_valid && n == rst_k) begin
                reset = 1'b1;
                #1;
                check("reset_async_zero",
                      longint'({acc_clear, partial_product, partial_product_valid, pp_overflow, busy, done}), 0);
                aborted = 1'b1;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int i = 0; i < 25; i++) @(posedge clk);
            #1;
            check("no_done_after_reset", done_cnt, 0);
            check("idle_after_reset", longint'(busy), 0);
            active = 1'b0;
            return;
        end
        check("done_seen_once", done_cnt, 1);
        check("acc_clear_once", clear_cnt, 1);
        check("acc_clear_cycle", clear_cyc - t0, 1);
        check("done_cycle", done_cyc - t0, 18 + stall_len);
        check("item_count", n, 16);
        check("busy_low_after_done", longint'(busy), 0);
        check("ovf_sticky_after_done", longint'(pp_overflow), longint'(model_ovf));
        if (!model_ovf) begin
            sum = 0;
            for (int k = 0; k < 16; k++) begin
`ifdef PPG_SIGNED_EN
                sum += longint'($signed(got[k])) <<< k;
`else
                sum += longint'(got[k]) <<< k;
`endif
            end
`ifdef PPG_SIGNED_EN
            prod = longint'($signed(a)) * longint'($signed(b));
`else
            prod = longint'(a) * longint'(b);
`endif
            check("weighted_sum", sum, prod);
        end
        active = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              longint'({acc_clear, partial_product, partial_product_valid, pp_overflow, busy, done}), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_state",
              longint'({acc_clear, partial_product, partial_product_valid, pp_overflow, busy, done}), 0);

        // 3 * 5: stream 3, 0, 3, then zeros
        run_mul(16'h0003, 16'h0005, -1, 0, -1, -1);
        check("t1_item0", longint'(got[0]), 16'h0003);
        check("t1_item1", longint'(got[1]), 16'h0000);
        check("t1_item2", longint'(got[2]), 16'h0003);
        for (int k = 3; k < 16; k++) check("t1_item_zero", longint'(got[k]), 0);

        // back-to-back, all ones
        run_mul(16'hFFFF, 16'hFFFF, -1, 0, -1, -1);
        check("t2_item7", longint'(got[7]), 16'hFFFF);

        // backpressure: 3 stall cycles at k = 5
        run_mul(16'h00A5, 16'h0F3C, 5, 3, -1, -1);
        check("t3_item5", longint'(got[5]), 16'h00A5);
        check("t3_item6", longint'(got[6]), 16'h0000);

        // start pulsed at cycle 8 is ignored
        run_mul(16'h1234, 16'hA5C3, -1, 0, 8, -1);
        check("t4_item0", longint'(got[0]), 16'h1234);
        check("t4_item2", longint'(got[2]), 16'h0000);

        // reset at k = 7, then a fresh multiply
        run_mul(16'h00FF, 16'hFFFF, -1, 0, -1, 7);
        run_mul(16'h0002, 16'h0001, -1, 0, -1, -1);
        check("t6_item0", longint'(got[0]), 16'h0002);
        for (int k = 1; k < 16; k++) check("t6_item_zero", longint'(got[k]), 0);

        // MSB-item cases
        run_mul(16'h0800, 16'hFFFF, -1, 0, -1, -1);
        check("t7_item0", longint'(got[0]), 16'h0800);
`ifdef PPG_SIGNED_EN
        check("t7_item15", longint'(got[15]), 16'hF800);
`else
        check("t7_item15", longint'(got[15]), 16'h0800);
`endif
        check("t7_ovf", longint'(pp_overflow), 0);

        run_mul(16'h8000, 16'h8000, -1, 0, -1, -1);
        check("t8_item0", longint'(got[0]), 16'h0000);
        check("t8_item15", longint'(got[15]), 16'h8000);
`ifdef PPG_SIGNED_EN
        check("t8_ovf", longint'(pp_overflow), 1);
`else
        check("t8_ovf", longint'(pp_overflow), 0);
`endif

        // next start clears the sticky flag (checked at acc_clear)
        run_mul(16'h0007, 16'h8001, -1, 0, -1, -1);
        check("t9_item0", longint'(got[0]), 16'h0007);
        check("t9_ovf", longint'(pp_overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
